// File: rtl/backend_pkg.sv
// Backend-wide widths, opcode encoding and the execute packet shared by the scheduler, register-read and execute stages.
package backend_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PREG_W  = 6;
  localparam int unsigned ROB_W   = 5;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned NUM_FWD = 2;

  typedef enum logic [OPC_W-1:0] {
    OPC_ADD  = 6'd0,
    OPC_SUB  = 6'd1,
    OPC_AND  = 6'd2,
    OPC_OR   = 6'd3,
    OPC_XOR  = 6'd4,
    OPC_SLL  = 6'd5,
    OPC_SRL  = 6'd6,
    OPC_SRA  = 6'd7,
    OPC_SLT  = 6'd8,
    OPC_SLTU = 6'd9
  } opcode_e;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic              alu_en;
    logic [XLEN-1:0]   src1_val;
    logic [XLEN-1:0]   src2_val;
    logic [PREG_W-1:0] dest_preg;
    logic [ROB_W-1:0]  rob_idx;
  } exec_packet_t;

endpackage

// File: rtl/reg_read_stage_if.sv
// Issue, regfile, forwarding and execute-side signals of the register-read stage.
interface reg_read_stage_if;
  import backend_pkg::*;

  logic                      iss_valid;
  logic                      iss_ready;
  logic [OPC_W-1:0]          iss_opcode;
  logic                      iss_alu_en;
  logic [PREG_W-1:0]         iss_src1_preg;
  logic [PREG_W-1:0]         iss_src2_preg;
  logic                      iss_use_imm;
  logic [XLEN-1:0]           iss_imm;
  logic [PREG_W-1:0]         iss_dest_preg;
  logic [ROB_W-1:0]          iss_rob_idx;
  logic [PREG_W-1:0]         rf_raddr1;
  logic [PREG_W-1:0]         rf_raddr2;
  logic [XLEN-1:0]           rf_rdata1;
  logic [XLEN-1:0]           rf_rdata2;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD*PREG_W-1:0] fwd_preg;
  logic [NUM_FWD*XLEN-1:0]   fwd_data;
  logic                      exec_valid;
  logic                      exec_ready;
  exec_packet_t              exec_pkt;

  // Surrounding pipeline: scheduler, regfile, forwarding buses and execute stage.
  modport master (
    output iss_valid, iss_opcode, iss_alu_en, iss_src1_preg, iss_src2_preg,
    output iss_use_imm, iss_imm, iss_dest_preg, iss_rob_idx,
    output rf_rdata1, rf_rdata2, fwd_valid, fwd_preg, fwd_data, exec_ready,
    input  iss_ready, rf_raddr1, rf_raddr2, exec_valid, exec_pkt
  );

  // The register-read stage itself.
  modport slave (
    input  iss_valid, iss_opcode, iss_alu_en, iss_src1_preg, iss_src2_preg,
    input  iss_use_imm, iss_imm, iss_dest_preg, iss_rob_idx,
    input  rf_rdata1, rf_rdata2, fwd_valid, fwd_preg, fwd_data, exec_ready,
    output iss_ready, rf_raddr1, rf_raddr2, exec_valid, exec_pkt
  );

endinterface

// File: rtl/operand_bypass_mux.sv
// Resolves one source operand: zero register, then lowest-index matching forward bus, then regfile data.
module operand_bypass_mux
  import backend_pkg::*;
(
  input  logic [PREG_W-1:0]         preg,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*PREG_W-1:0] fwd_preg,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic [XLEN-1:0]           rf_data,
  output logic [XLEN-1:0]           value
);

  logic hit;

  // First match wins, so lower-numbered buses (younger results) take priority.
  always_comb begin
    value = rf_data;
    hit   = 1'b0;
    for (int i = 0; i < int'(NUM_FWD); i++) begin
      if (!hit && fwd_valid[i] && (fwd_preg[i*PREG_W +: PREG_W] == preg)) begin
        value = fwd_data[i*XLEN +: XLEN];
        hit   = 1'b1;
      end
    end
    if (preg == '0) begin
      value = '0;
    end
  end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage: reads both sources, applies bypass/immediate, and registers the execute packet.
module reg_read_stage
  import backend_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  reg_read_stage_if.slave  bus
);

  logic         valid_q;
  exec_packet_t pkt_q;
  exec_packet_t pkt_d;
  logic         ready_c;
  logic         accept_c;
  logic [XLEN-1:0] src1_fwd;
  logic [XLEN-1:0] src2_fwd;

  assign bus.rf_raddr1 = bus.iss_src1_preg;
  assign bus.rf_raddr2 = bus.iss_src2_preg;

  assign ready_c       = !valid_q || bus.exec_ready;
  assign accept_c      = bus.iss_valid && ready_c && !flush;
  assign bus.iss_ready = ready_c;

  operand_bypass_mux u_src1_mux (
    .preg      (bus.iss_src1_preg),
    .fwd_valid (bus.fwd_valid),
    .fwd_preg  (bus.fwd_preg),
    .fwd_data  (bus.fwd_data),
    .rf_data   (bus.rf_rdata1),
    .value     (src1_fwd)
  );

  operand_bypass_mux u_src2_mux (
    .preg      (bus.iss_src2_preg),
    .fwd_valid (bus.fwd_valid),
    .fwd_preg  (bus.fwd_preg),
    .fwd_data  (bus.fwd_data),
    .rf_data   (bus.rf_rdata2),
    .value     (src2_fwd)
  );

  // Assemble the packet to capture; an immediate overrides any src2 bypass.
  always_comb begin
    pkt_d           = '0;
    pkt_d.opcode    = bus.iss_opcode;
    pkt_d.alu_en    = bus.iss_alu_en;
    pkt_d.src1_val  = src1_fwd;
    pkt_d.src2_val  = bus.iss_use_imm ? bus.iss_imm : src2_fwd;
    pkt_d.dest_preg = bus.iss_dest_preg;
    pkt_d.rob_idx   = bus.iss_rob_idx;
  end

  // Output register: flush beats accept, accept beats drain, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept_c) begin
      valid_q <= 1'b1;
      pkt_q   <= pkt_d;
    end else if (bus.exec_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.exec_valid = valid_q;
  assign bus.exec_pkt   = pkt_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Self-checking bench for reg_read_stage: directed vector table, corner sequences and randomized traffic vs. a reference model.
module tb_reg_read_stage;
  import backend_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  reg_read_stage_if bus ();

  reg_read_stage u_dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: what the execute stage should currently see.
  bit           m_valid;
  exec_packet_t m_pkt;

  // Forwarding buses as unpacked arrays; packed onto the interface by drive_fwd.
  logic [NUM_FWD-1:0] fv;
  logic [PREG_W-1:0]  fp [NUM_FWD];
  logic [XLEN-1:0]    fd [NUM_FWD];

  typedef struct {
    logic [PREG_W-1:0] s1;
    logic [PREG_W-1:0] s2;
    logic              use_imm;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [1:0]        fvv;
    logic [PREG_W-1:0] fp0;
    logic [PREG_W-1:0] fp1;
    logic [XLEN-1:0]   fd0;
    logic [XLEN-1:0]   fd1;
    logic [XLEN-1:0]   exp1;
    logic [XLEN-1:0]   exp2;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fwd();
    bus.fwd_valid = fv;
    for (int i = 0; i < int'(NUM_FWD); i++) begin
      bus.fwd_preg[i*PREG_W +: PREG_W] = fp[i];
      bus.fwd_data[i*XLEN +: XLEN]     = fd[i];
    end
  endtask

  // Operand value from the architectural rules: p0 is zero, forwarding beats the regfile, lowest bus wins.
  function automatic logic [XLEN-1:0] ref_operand(input logic [PREG_W-1:0] p, input logic [XLEN-1:0] rd);
    if (p == '0) return '0;
    for (int i = 0; i < int'(NUM_FWD); i++)
      if (fv[i] && fp[i] == p) return fd[i];
    return rd;
  endfunction

  // One clock: check combinational outputs, predict the next state, advance, compare.
  task automatic step();
    bit           rdy;
    bit           acc;
    exec_packet_t nxt;
    #1;
    rdy = !m_valid || bus.exec_ready;
    chk("iss_ready", 128'(bus.iss_ready), 128'(rdy));
    chk("rf_raddr1", 128'(bus.rf_raddr1), 128'(bus.iss_src1_preg));
    chk("rf_raddr2", 128'(bus.rf_raddr2), 128'(bus.iss_src2_preg));
    acc = bus.iss_valid && rdy && !flush;
    nxt.opcode    = bus.iss_opcode;
    nxt.alu_en    = bus.iss_alu_en;
    nxt.src1_val  = ref_operand(bus.iss_src1_preg, bus.rf_rdata1);
    nxt.src2_val  = bus.iss_use_imm ? bus.iss_imm : ref_operand(bus.iss_src2_preg, bus.rf_rdata2);
    nxt.dest_preg = bus.iss_dest_preg;
    nxt.rob_idx   = bus.iss_rob_idx;
    if (flush)                m_valid = 1'b0;
    else if (acc)             begin m_valid = 1'b1; m_pkt = nxt; end
    else if (bus.exec_ready)  m_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("exec_valid", 128'(bus.exec_valid), 128'(m_valid));
    if (m_valid) chk("exec_pkt", 128'(bus.exec_pkt), 128'(m_pkt));
  endtask

  task automatic set_uop(input logic [PREG_W-1:0] s1, input logic [PREG_W-1:0] s2,
                         input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2,
                         input logic [PREG_W-1:0] dest, input logic [ROB_W-1:0] rob);
    bus.iss_opcode    = OPC_ADD;
    bus.iss_alu_en    = 1'b1;
    bus.iss_src1_preg = s1;
    bus.iss_src2_preg = s2;
    bus.iss_use_imm   = 1'b0;
    bus.iss_imm       = '0;
    bus.iss_dest_preg = dest;
    bus.iss_rob_idx   = rob;
    bus.rf_rdata1     = rd1;
    bus.rf_rdata2     = rd2;
  endtask

  initial begin
    //               s1  s2  imm? imm           rd1          rd2          fv     fp0 fp1 fd0          fd1          exp1         exp2
    vecs[0] = '{6'd5, 6'd7, 1'b0, 32'h0,        32'h11,      32'h22,      2'b00, 6'd0, 6'd0, 32'h0,   32'h0,       32'h11,      32'h22};
    vecs[1] = '{6'd9, 6'd3, 1'b0, 32'h0,        32'hC,       32'h33,      2'b11, 6'd9, 6'd9, 32'hA,   32'hB,       32'hA,       32'h33};
    vecs[2] = '{6'd0, 6'd4, 1'b0, 32'h0,        32'h55,      32'h44,      2'b01, 6'd0, 6'd0, 32'hDEAD,32'h0,       32'h0,       32'h44};
    vecs[3] = '{6'd1, 6'd8, 1'b1, 32'hFFFFFFF0, 32'h1,       32'h77,      2'b01, 6'd8, 6'd0, 32'h99,  32'h0,       32'h1,       32'hFFFFFFF0};
    vecs[4] = '{6'd6, 6'd6, 1'b0, 32'h0,        32'h60,      32'h61,      2'b10, 6'd0, 6'd6, 32'h0,   32'h66,      32'h66,      32'h66};
    vecs[5] = '{6'd11,6'd10,1'b0, 32'h0,        32'h111,     32'h222,     2'b01, 6'd10,6'd0, 32'hAA,  32'h0,       32'h111,     32'hAA};

    rst = 1'b0; flush = 1'b0;
    bus.iss_valid = 1'b0; bus.exec_ready = 1'b1;
    set_uop('0, '0, '0, '0, '0, '0);
    fv = '0; fp = '{default: '0}; fd = '{default: '0}; drive_fwd();
    m_valid = 1'b0; m_pkt = '0;

    // Reset state
    #12;
    chk("reset exec_valid", 128'(bus.exec_valid), 128'(0));
    chk("reset exec_pkt", 128'(bus.exec_pkt), 128'(0));
    chk("reset iss_ready", 128'(bus.iss_ready), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vector table, back-to-back with exec_ready high
    bus.iss_valid = 1'b1; bus.exec_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_uop(vecs[k].s1, vecs[k].s2, vecs[k].rd1, vecs[k].rd2, PREG_W'(20 + k), ROB_W'(k + 1));
      bus.iss_use_imm = vecs[k].use_imm;
      bus.iss_imm     = vecs[k].imm;
      fv = vecs[k].fvv; fp[0] = vecs[k].fp0; fp[1] = vecs[k].fp1; fd[0] = vecs[k].fd0; fd[1] = vecs[k].fd1;
      drive_fwd();
      step();
      chk($sformatf("vec%0d valid", k), 128'(bus.exec_valid), 128'(1));
      chk($sformatf("vec%0d src1", k), 128'(bus.exec_pkt.src1_val), 128'(vecs[k].exp1));
      chk($sformatf("vec%0d src2", k), 128'(bus.exec_pkt.src2_val), 128'(vecs[k].exp2));
      chk($sformatf("vec%0d dest", k), 128'(bus.exec_pkt.dest_preg), 128'(20 + k));
      chk($sformatf("vec%0d rob", k), 128'(bus.exec_pkt.rob_idx), 128'(k + 1));
    end
    fv = '0; drive_fwd();

    // Backpressure: hold for 3 cycles, then release with a new uop and no bubble
    set_uop(6'd5, 6'd7, 32'h11, 32'h22, 6'd30, 5'd3);
    step();
    bus.exec_ready = 1'b0;
    set_uop(6'd2, 6'd3, 32'h5555, 32'h6666, 6'd31, 5'd4);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall iss_ready", 128'(bus.iss_ready), 128'(0));
      chk("stall held src1", 128'(bus.exec_pkt.src1_val), 128'(32'h11));
      chk("stall held dest", 128'(bus.exec_pkt.dest_preg), 128'(30));
    end
    bus.exec_ready = 1'b1;
    bus.rf_rdata1 = 32'h99;
    step();
    chk("release valid", 128'(bus.exec_valid), 128'(1));
    chk("release src1", 128'(bus.exec_pkt.src1_val), 128'(32'h99));
    chk("release dest", 128'(bus.exec_pkt.dest_preg), 128'(31));

    // Flush with held packet and simultaneous issue
    bus.exec_ready = 1'b0;
    set_uop(6'd4, 6'd5, 32'h77, 32'h78, 6'd40, 5'd9);
    flush = 1'b1;
    step();
    chk("flush valid", 128'(bus.exec_valid), 128'(0));
    flush = 1'b0; bus.iss_valid = 1'b0; bus.exec_ready = 1'b1;
    step();
    chk("after flush valid", 128'(bus.exec_valid), 128'(0));

    // Async reset mid-stream while a packet is valid
    bus.iss_valid = 1'b1;
    step();
    chk("pre-reset valid", 128'(bus.exec_valid), 128'(1));
    rst = 1'b0;
    #1;
    chk("async reset valid", 128'(bus.exec_valid), 128'(0));
    chk("async reset pkt", 128'(bus.exec_pkt), 128'(0));
    chk("async reset iss_ready", 128'(bus.iss_ready), 128'(1));
    m_valid = 1'b0; m_pkt = '0;
    #2 rst = 1'b1;

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      bus.iss_valid     = ($urandom_range(0, 3) != 0);
      bus.exec_ready    = ($urandom_range(0, 3) != 0);
      flush             = ($urandom_range(0, 15) == 0);
      bus.iss_opcode    = OPC_W'($urandom_range(0, 9));
      bus.iss_alu_en    = 1'($urandom);
      bus.iss_src1_preg = PREG_W'($urandom_range(0, 7));
      bus.iss_src2_preg = PREG_W'($urandom_range(0, 7));
      bus.iss_use_imm   = 1'($urandom);
      bus.iss_imm       = $urandom;
      bus.iss_dest_preg = PREG_W'($urandom);
      bus.iss_rob_idx   = ROB_W'($urandom);
      bus.rf_rdata1     = $urandom;
      bus.rf_rdata2     = $urandom;
      fv = NUM_FWD'($urandom);
      for (int i = 0; i < int'(NUM_FWD); i++) begin
        fp[i] = PREG_W'($urandom_range(0, 7));
        fd[i] = $urandom;
      end
      drive_fwd();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
